soc_system_clk_enable_bank: RTL and testbench

Parametrised multi-channel clock-enable and divided-clock generator that sits downstream of the system PLL. It runs in one PLL output clock domain. It supervises the PLL lock with a settle period, then produces NUM_CH phase-aligned enable strobes and square-wave divided clocks. Each channel has a runtime-programmable divide ratio, phase offset and enable, so sub-rate logic (camera, motor PWM, video timing) runs on one clock without extra PLL outputs.

---
 rtl/soc_system_clk_enable_bank.sv | 149 ++++++++++++++
 tb/tb_soc_system_clk_enable_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/soc_system_clk_enable_bank.sv
// Lock-supervised bank of phase-aligned clock-enable strobes and divided clocks.
// One down-counter per channel; all channels reload together so phases stay aligned.

module soc_system_clk_enable_bank_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             reload,
  input  logic             en,
  input  logic [CNT_W-1:0] ratio,
  input  logic [CNT_W-1:0] phase,
  output logic             ce,
  output logic             div_out
);
  logic [CNT_W-1:0] cnt, neff, peff;

  always_comb begin
    neff = (ratio == '0) ? CNT_W'(1) : ratio;
    peff = (phase < neff) ? phase : neff - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      ce      <= 1'b0;
      div_out <= 1'b0;
    end else if (reload) begin
      cnt     <= peff;
      ce      <= 1'b0;
      div_out <= 1'b0;
    end else if (!run) begin
      ce      <= 1'b0;
      div_out <= 1'b0;
    end else if (!en) begin
      cnt     <= peff;
      ce      <= 1'b0;
      div_out <= 1'b0;
    end else if (cnt == '0) begin
      cnt     <= neff - CNT_W'(1);
      ce      <= 1'b1;
      div_out <= (neff != CNT_W'(1));
    end else begin
      cnt     <= cnt - CNT_W'(1);
      ce      <= 1'b0;
      // high only after a ce, for counter values neff-1 down to floor(neff/2)
      div_out <= div_out && ((cnt - CNT_W'(1)) >= (neff >> 1));
    end
  end
endmodule

module soc_system_clk_enable_bank #(
  parameter int NUM_CH        = 6,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int DEF_RATIO     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*CNT_W-1:0] cfg_ratio,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic                    locked_sync,
  output logic                    running,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       div_out
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  // counter reaches SETTLE_CYCLES-1 on the edge that enters RUN
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t                        state;
  logic                          sync_q;
  logic [SW-1:0]                 settle_cnt;
  logic                          reload_pend;
  logic [NUM_CH-1:0][CNT_W-1:0]  sh_ratio, sh_phase;
  logic                          run_act, enter_run, reload;

  assign run_act   = (state == RUN) && locked_sync;
  assign enter_run = locked_sync &&
                     (((state == WAIT_LOCK) && (SETTLE_CYCLES == 1)) ||
                      ((state == SETTLE) && (settle_cnt == SETTLE_LAST)));
  assign reload    = enter_run || (run_act && reload_pend);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= 1'b0;
      locked_sync <= 1'b0;
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      running     <= 1'b0;
      reload_pend <= 1'b0;
      sh_ratio    <= {NUM_CH{CNT_W'(DEF_RATIO)}};
      sh_phase    <= '0;
    end else begin
      sync_q      <= pll_locked;
      locked_sync <= sync_q;
      reload_pend <= run_act && cfg_load;
      if (cfg_load) begin
        sh_ratio <= cfg_ratio;
        sh_phase <= cfg_phase;
      end
      if (!locked_sync) begin
        state   <= WAIT_LOCK;
        running <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            settle_cnt <= '0;
            if (enter_run) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
          SETTLE: begin
            settle_cnt <= settle_cnt + SW'(1);
            if (enter_run) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN:     running <= 1'b1;
          default: state   <= WAIT_LOCK;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soc_system_clk_enable_bank_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run_act),
      .reload  (reload),
      .en      (ch_enable[i]),
      .ratio   (sh_ratio[i]),
      .phase   (sh_phase[i]),
      .ce      (ce[i]),
      .div_out (div_out[i])
    );
  end
endmodule

// File: tb/tb_soc_system_clk_enable_bank.sv
// Randomised scoreboard bench: a time-anchored reference model predicts every output each cycle.

module tb_soc_system_clk_enable_bank;
  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;
  localparam int SC     = 8;
  localparam int DEF    = 4;

  typedef struct {
    logic              ls;
    logic              run;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] dv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, pll, load;
  logic [NUM_CH-1:0]            en;
  logic [NUM_CH-1:0][CNT_W-1:0] ratio, phase;
  logic                         locked_sync, running;
  logic [NUM_CH-1:0]            ce, div_out;

  soc_system_clk_enable_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SETTLE_CYCLES(SC), .DEF_RATIO(DEF)
  ) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .pll_locked  (pll),
    .cfg_ratio   (ratio),
    .cfg_phase   (phase),
    .cfg_load    (load),
    .ch_enable   (en),
    .locked_sync (locked_sync),
    .running     (running),
    .ce          (ce),
    .div_out     (div_out)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;

  // reference model state: lock streak, shadow config, per-channel time anchor
  bit m_s1, m_ls, m_run, m_pend;
  int m_streak, t;
  int sh_r[NUM_CH], sh_p[NUM_CH], anc[NUM_CH], an_n[NUM_CH], an_p[NUM_CH];

  function automatic int neff(input int r);
    return (r == 0) ? 1 : r;
  endfunction
  function automatic int peff(input int p, input int n);
    return (p < n) ? p : n - 1;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit act, enter, rl;
    int n, p, k;
    t++;
    e.ce = '0;
    e.dv = '0;
    if (!rst_n) begin
      m_s1 = 0; m_ls = 0; m_run = 0; m_pend = 0; m_streak = 0;
      for (int i = 0; i < NUM_CH; i++) begin sh_r[i] = DEF; sh_p[i] = 0; end
    end else begin
      act      = m_run && m_ls;
      m_streak = m_ls ? m_streak + 1 : 0;
      enter    = (m_streak >= SC) && !m_run;
      rl       = enter || (act && m_pend);
      m_run    = (m_streak >= SC);
      m_ls     = m_s1;
      m_s1     = pll;
      m_pend   = act && load;
      for (int i = 0; i < NUM_CH; i++) begin
        n = neff(sh_r[i]);
        p = peff(sh_p[i], n);
        if (rl || (act && !en[i])) begin
          anc[i] = t; an_n[i] = n; an_p[i] = p;
        end else if (act) begin
          k = t - anc[i] - an_p[i] - 1;
          e.ce[i] = (k >= 0) && (k % an_n[i] == 0);
          e.dv[i] = (k >= 0) && (an_n[i] >= 2) && ((k % an_n[i]) < (an_n[i] + 1) / 2);
        end
        if (load) begin sh_r[i] = int'(ratio[i]); sh_p[i] = int'(phase[i]); end
      end
    end
    e.ls  = m_ls;
    e.run = m_run;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      if (fails <= 30) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked_sync", 32'(locked_sync), 32'(e.ls));
        chk("running",     32'(running),     32'(e.run));
        chk("ce",          32'(ce),          32'(e.ce));
        chk("div_out",     32'(div_out),     32'(e.dv));
      end
    end
  end

  task automatic set_ch(input int i, input int r, input int p);
    ratio[i] = CNT_W'(r);
    phase[i] = CNT_W'(p);
  endtask

  initial begin : stim
    rst_n = 0; pll = 0; load = 0; en = '1; ratio = '0; phase = '0;
    @(negedge clk);
    step(3);
    rst_n = 1;
    step(2);
    // ch3 N=0, ch4 P beyond N, ch5 maximum ratio
    set_ch(0, 4, 0); set_ch(1, 5, 2); set_ch(2, 1, 0);
    set_ch(3, 0, 0); set_ch(4, 4, 7); set_ch(5, 255, 0);
    load = 1; step(1); load = 0;
    pll = 1;
    step(300);
    // reload alignment
    set_ch(0, 3, 0); set_ch(1, 6, 0);
    load = 1; step(1); load = 0;
    step(30);
    // channel enable toggle
    set_ch(3, 5, 2);
    load = 1; step(1); load = 0;
    step(6);
    en[3] = 0; step(7);
    en[3] = 1; step(20);
    // lock loss coinciding with cfg_load at the state machine
    set_ch(0, 7, 1); set_ch(1, 2, 0);
    pll = 0; step(2);
    load = 1; step(1); load = 0;
    step(5);
    pll = 1; step(40);
    // reset while running: defaults return
    rst_n = 0; step(1); rst_n = 1;
    step(40);
    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      load = 0;
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < NUM_CH; i++)
          set_ch(i, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 11)));
        load = 1;
      end
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if (pll && $urandom_range(0, 499) == 0) pll = 0;
      else if (!pll && $urandom_range(0, 19) == 0) pll = 1;
      rst_n = ($urandom_range(0, 1499) != 0);
      step(1);
    end
    load = 0; rst_n = 1;
    step(3);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
